// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet transmit path.
// Inter-frame gap and RMII rate constants live here so every block derives the same timing.
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_arb_state_t;

  localparam int ETH_IFG_BITS      = 96;
  localparam int RMII_BITS_PER_CLK = 2;

  // Index width that stays legal (>= 1) even for a count of one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eth_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
// Returns a one-hot pick and an any-request flag.
module rr_pick
  import eth_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               any
);

  localparam logic [PTR_W:0] NUM_L = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W:0] idx;
  logic           found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(i);
      if (idx >= NUM_L) begin
        idx = idx - NUM_L;
      end
      if (!found && req[idx[PTR_W-1:0]]) begin
        pick[idx[PTR_W-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/eth_tx_arbiter.sv
// Whole-frame round-robin arbiter feeding the single Ethernet TX serializer,
// with the inter-frame gap enforced before the next grant.
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int IFG_CYCLES = ETH_IFG_BITS / RMII_BITS_PER_CLK,
  parameter int CNT_W      = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic [CNT_W-1:0]     byte_cnt,
  output tx_arb_state_t        dbg_state
);

  localparam int PTR_W = idx_width(NUM_REQ);
  localparam int GAP_W = idx_width(IFG_CYCLES);

  tx_arb_state_t      state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;

  logic [NUM_REQ-1:0] pick;
  logic               pick_any;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic               xfer;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req  (req_valid),
    .ptr  (rr_ptr_q),
    .pick (pick),
    .any  (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        pick_idx = PTR_W'(i);
      end
    end
  end

  // The source just served drops to lowest priority for the next arbitration.
  assign next_ptr = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);

  // Handshake: a byte moves on any cycle where valid and ready are both high.
  // Valid never depends on ready; the owner's req_ready is the serializer's
  // out_ready passed straight back, and every other req_ready stays low.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    gap_d      = gap_q;
    byte_cnt_d = byte_cnt_q;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    req_ready  = '0;
    xfer       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d    = pick;
          owner_d    = pick_idx;
          byte_cnt_d = '0;
          state_d    = SEND;
        end
      end

      SEND: begin
        out_valid = req_valid[owner_q];
        out_data  = req_data[{owner_q, 3'b000} +: 8];
        out_last  = req_last[owner_q];
        req_ready = grant_q & {NUM_REQ{out_ready}};
        xfer      = out_valid && out_ready;
        if (xfer) begin
          if (byte_cnt_q != '1) begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
          if (out_last) begin
            state_d  = GAP;
            rr_ptr_d = next_ptr;
            gap_d    = GAP_W'(IFG_CYCLES - 1);
            grant_d  = '0;
          end
        end
      end

      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      gap_q      <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      gap_q      <= gap_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign byte_cnt  = byte_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Shares the single Ethernet transmit path inside network_stack between NUM_REQ frame sources (e.g. ARP responder, UDP sender).
- Grants whole frames round-robin and passes the granted source's byte stream to the TX serializer.
- Enforces the inter-frame gap before the next grant.
- Runs in the eth_refclk (50 MHz) domain.

Parameters:
- NUM_REQ, 2: number of requesting frame sources (2..8).
- IFG_CYCLES, 48: idle cycles inserted after each frame's last byte (96 bit-times at 2 bits/clk).
- CNT_W, 11: width of the frame byte counter (frames up to 2047 bytes).

Ports:
- clk  in  1  eth_refclk domain clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-source byte valid.
- req_data  in  NUM_REQ*8  per-source byte; source i occupies bits [8i+7:8i].
- req_last  in  NUM_REQ  per-source final-byte-of-frame flag.
- req_ready  out  NUM_REQ  per-source accept.
- out_valid  out  1  byte valid to serializer.
- out_data  out  8  byte to serializer.
- out_last  out  1  final byte of frame.
- out_ready  in  1  serializer accept.
- grant  out  NUM_REQ  one-hot current owner; zero when not in SEND.
- busy  out  1  high in SEND or GAP.
- byte_cnt  out  CNT_W  bytes transferred in the current/last frame.

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values:
  - state=IDLE, grant=0, rr_ptr=0, gap counter=0, byte_cnt=0.
  - out_valid=0, out_last=0, out_data=0, req_ready=0, busy=0.
- IDLE:
  - If any req_valid is set, pick the first set index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Register the pick as one-hot grant, clear byte_cnt, go to SEND next cycle.
  - Grant latency is 1 cycle. No byte is transferred in IDLE.
- SEND (owner g), combinational pass-through:
  - out_valid=req_valid[g], out_data=req_data[g], out_last=req_last[g].
  - req_ready[g]=out_ready; every other req_ready=0.
  - A transfer occurs when out_valid && out_ready. Each transfer increments byte_cnt, saturating at all-ones.
  - Transfer with out_last=1: go to GAP, set rr_ptr=(g+1) mod NUM_REQ, load gap counter with IFG_CYCLES-1, clear grant.
  - Owner dropping req_valid mid-frame stalls the output (out_valid=0) and holds the grant. The frame is never preempted.
- GAP:
  - All outputs are idle and all req_ready=0.
  - The counter decrements each cycle; at 0 go to IDLE.
  - Exactly IFG_CYCLES cycles lie between the last-byte handshake and the IDLE cycle. The earliest next first-byte transfer is IFG_CYCLES+2 cycles after the last-byte handshake.
- Non-owner sources: req_ready stays 0. Their valid/data may change freely and have no effect.
- Simultaneous requests in IDLE: round-robin order decides. The last-served source has lowest priority next time.
- Single-byte frame (first byte has req_last=1): SEND lasts one handshake, then GAP.
- Reset mid-frame or mid-gap: the abort is immediate; the next cycle is IDLE with reset values. The partial frame is dropped.
- busy = (state != IDLE). byte_cnt holds its value through GAP and IDLE until the next grant.

Decomposition:
- Package eth_pkg holds:
  - typedef enum logic [1:0] {IDLE, SEND, GAP} tx_arb_state_t
  - localparam ETH_IFG_BITS = 96
  - localparam RMII_BITS_PER_CLK = 2
- IFG_CYCLES defaults to ETH_IFG_BITS / RMII_BITS_PER_CLK.
- One sub-module, rr_pick: combinational round-robin selector. Inputs are the request vector and rr_ptr; output is a one-hot pick plus an any flag. It is reused by future RX-side fan-out logic.

Test Plan:
1. Reset, then source 0 sends a 4-byte frame (0x11, 0x22, 0x33, 0x44, last on 0x44) with out_ready=1.
   -> grant=01 one cycle after valid; four bytes appear in order; byte_cnt=4; busy high for 4+48 cycles; then IDLE.
2. Both sources valid in the same IDLE cycle after reset.
   -> source 0 granted first; after its last byte plus 48 gap cycles, source 1 granted; a third contention grants source 0 again.
3. Backpressure: out_ready toggles 1,0,1,0 during a 3-byte frame from source 1.
   -> each byte is held stable while out_ready=0; req_ready[1] mirrors out_ready; req_ready[0]=0 throughout.
4. Source 1 valid while source 0 is mid-frame.
   -> no preemption; source 1 is granted only after source 0's last byte and exactly IFG_CYCLES gap cycles.
5. rst asserted on the 2nd byte of a frame, then released.
   -> next cycle all outputs are 0 and state is IDLE; a fresh request is granted with byte_cnt restarting at 0.
6. Single-byte frame (0xAB with last) from source 0, then an immediate re-request.
   -> out_last=1 on the only byte; the next first-byte transfer occurs no earlier than IFG_CYCLES+2 cycles after the last-byte handshake.
